// File: rtl/cpu_trace_emitter.sv
// cpu_trace_emitter
//   Serialises one CPU write record into an ASCII trace line, one character per cycle:
//     "^" time "@" pc ": " operand " <= " data "#"
//   Time is decimal (clamped to 9999), pc/addr/data are 8 lowercase hex digits, and the
//   operand is "$<reg>" (register write) or "*<addr>" (memory write).
// Ports
//   clk, reset          : clock, asynchronous active-low reset
//   rec_valid/rec_ready : record handshake; all rec_* fields are latched on acceptance
//   rec_kind            : 0 = register write, 1 = memory write
//   rec_time/pc/reg/addr/data : record fields
//   char, char_valid    : registered character stream
//   records_sent        : count of completely emitted records (wraps)
module cpu_trace_emitter (
   input  logic        clk,
   input  logic        reset,
   input  logic        rec_valid,
   output logic        rec_ready,
   input  logic        rec_kind,
   input  logic [13:0] rec_time,
   input  logic [31:0] rec_pc,
   input  logic [4:0]  rec_reg,
   input  logic [31:0] rec_addr,
   input  logic [31:0] rec_data,
   output logic [7:0]  char,
   output logic        char_valid,
   output logic [15:0] records_sent
);

   typedef enum logic [3:0] {
      StIdle, StTime, StAt, StPc, StColon, StSp1, StOpsig, StOpnd,
      StSp2, StLt, StEq, StSp3, StData, StHash
   } state_e;

   localparam logic [7:0] ChCaret = 8'h5e;
   localparam logic [7:0] ChAt    = 8'h40;
   localparam logic [7:0] ChColon = 8'h3a;
   localparam logic [7:0] ChSpace = 8'h20;
   localparam logic [7:0] ChDolar = 8'h24;
   localparam logic [7:0] ChStar  = 8'h2a;
   localparam logic [7:0] ChLt    = 8'h3c;
   localparam logic [7:0] ChEq    = 8'h3d;
   localparam logic [7:0] ChHash  = 8'h23;

   state_e      state_q, state_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [7:0]  char_q, char_d;
   logic        char_valid_q, char_valid_d;
   logic [15:0] records_sent_q;

   logic        kind_q;
   logic [13:0] time_q;
   logic [31:0] pc_q, addr_q, data_q;
   logic [4:0]  reg_q;

   logic        accept;
   logic [3:0]  time_dig [4];
   logic [2:0]  time_ndig;
   logic [3:0]  reg_tens, reg_ones;
   logic [2:0]  reg_ndig;
   logic [2:0]  opnd_last;

   function automatic logic [7:0] dec_char(input logic [3:0] d);
      return 8'h30 + {4'h0, d};
   endfunction

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
   endfunction

   // Nibble k of v counted from the most significant end.
   function automatic logic [3:0] nib(input logic [31:0] v, input logic [2:0] k);
      logic [4:0] sh;
      sh = {~k, 2'b00};
      return 4'(v >> sh);
   endfunction

   // The "#" cycle doubles as the acceptance slot so records can stream back to back.
   assign rec_ready    = (state_q == StIdle) || (state_q == StHash);
   assign accept       = rec_valid && rec_ready;
   assign char         = char_q;
   assign char_valid   = char_valid_q;
   assign records_sent = records_sent_q;

   // Decimal digit decomposition of the latched (already clamped) time and register.
   always_comb begin
      time_dig[3] = 4'(time_q / 14'd1000);
      time_dig[2] = 4'((time_q / 14'd100) % 14'd10);
      time_dig[1] = 4'((time_q / 14'd10) % 14'd10);
      time_dig[0] = 4'(time_q % 14'd10);
      if (time_q >= 14'd1000)     time_ndig = 3'd4;
      else if (time_q >= 14'd100) time_ndig = 3'd3;
      else if (time_q >= 14'd10)  time_ndig = 3'd2;
      else                        time_ndig = 3'd1;
      reg_tens  = 4'(reg_q / 5'd10);
      reg_ones  = 4'(reg_q % 5'd10);
      reg_ndig  = (reg_q >= 5'd10) ? 3'd2 : 3'd1;
      opnd_last = kind_q ? 3'd7 : (reg_ndig - 3'd1);
   end

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= 3'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // FSM next state. TIME covers the leading "^" (cnt 0) followed by the time digits.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         StIdle: begin
            if (accept) begin
               state_d = StTime;
               cnt_d   = 3'd0;
            end
         end
         StTime: begin
            if (cnt_q == time_ndig) begin
               state_d = StAt;
               cnt_d   = 3'd0;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         StAt:    state_d = StPc;
         StPc: begin
            if (cnt_q == 3'd7) begin
               state_d = StColon;
               cnt_d   = 3'd0;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         StColon: state_d = StSp1;
         StSp1:   state_d = StOpsig;
         StOpsig: state_d = StOpnd;
         StOpnd: begin
            if (cnt_q == opnd_last) begin
               state_d = StSp2;
               cnt_d   = 3'd0;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         StSp2:   state_d = StLt;
         StLt:    state_d = StEq;
         StEq:    state_d = StSp3;
         StSp3:   state_d = StData;
         StData: begin
            if (cnt_q == 3'd7) begin
               state_d = StHash;
               cnt_d   = 3'd0;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         StHash: begin
            state_d = accept ? StTime : StIdle;
            cnt_d   = 3'd0;
         end
         default: begin
            state_d = StIdle;
            cnt_d   = 3'd0;
         end
      endcase
   end

   // FSM output: the character for the state being entered, registered below.
   always_comb begin
      char_d       = 8'h00;
      char_valid_d = (state_d != StIdle);
      case (state_d)
         StTime:  char_d = (cnt_d == 3'd0) ? ChCaret
                                           : dec_char(time_dig[2'(time_ndig - cnt_d)]);
         StAt:    char_d = ChAt;
         StPc:    char_d = hex_char(nib(pc_q, cnt_d));
         StColon: char_d = ChColon;
         StSp1:   char_d = ChSpace;
         StOpsig: char_d = kind_q ? ChStar : ChDolar;
         StOpnd: begin
            if (kind_q) char_d = hex_char(nib(addr_q, cnt_d));
            else if ((reg_ndig == 3'd2) && (cnt_d == 3'd0)) char_d = dec_char(reg_tens);
            else char_d = dec_char(reg_ones);
         end
         StSp2:   char_d = ChSpace;
         StLt:    char_d = ChLt;
         StEq:    char_d = ChEq;
         StSp3:   char_d = ChSpace;
         StData:  char_d = hex_char(nib(data_q, cnt_d));
         StHash:  char_d = ChHash;
         default: char_d = 8'h00;
      endcase
   end

   // Datapath: output register, record latch, completion counter.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         char_q         <= 8'h00;
         char_valid_q   <= 1'b0;
         records_sent_q <= 16'h0000;
         kind_q         <= 1'b0;
         time_q         <= 14'd0;
         pc_q           <= 32'h0;
         reg_q          <= 5'd0;
         addr_q         <= 32'h0;
         data_q         <= 32'h0;
      end else begin
         char_q       <= char_d;
         char_valid_q <= char_valid_d;
         if (state_q == StHash) records_sent_q <= records_sent_q + 16'd1;
         if (accept) begin
            kind_q <= rec_kind;
            time_q <= (rec_time > 14'd9999) ? 14'd9999 : rec_time;
            pc_q   <= rec_pc;
            reg_q  <= rec_reg;
            addr_q <= rec_addr;
            data_q <= rec_data;
         end
      end
   end

endmodule

// File: tb/tb_cpu_trace_emitter.sv
module tb_cpu_trace_emitter;

   logic        clk = 1'b0;
   logic        reset;
   logic        rec_valid;
   logic        rec_ready;
   logic        rec_kind;
   logic [13:0] rec_time;
   logic [31:0] rec_pc;
   logic [4:0]  rec_reg;
   logic [31:0] rec_addr;
   logic [31:0] rec_data;
   logic [7:0]  char;
   logic        char_valid;
   logic [15:0] records_sent;

   int          checks = 0;
   int          errors = 0;
   logic [15:0] exp_sent = 16'h0000;

   cpu_trace_emitter dut (
      .clk          (clk),
      .reset        (reset),
      .rec_valid    (rec_valid),
      .rec_ready    (rec_ready),
      .rec_kind     (rec_kind),
      .rec_time     (rec_time),
      .rec_pc       (rec_pc),
      .rec_reg      (rec_reg),
      .rec_addr     (rec_addr),
      .rec_data     (rec_data),
      .char         (char),
      .char_valid   (char_valid),
      .records_sent (records_sent)
   );

   always #5 clk = ~clk;

   // Reference: the trace line a record must produce.
   function automatic string model(input bit kind, input logic [13:0] t, input logic [31:0] pc,
                                   input logic [4:0] r, input logic [31:0] addr,
                                   input logic [31:0] data);
      int    tc;
      string op;
      tc = (int'(t) > 9999) ? 9999 : int'(t);
      op = kind ? $sformatf("*%08h", addr) : $sformatf("$%0d", r);
      return $sformatf("^%0d@%08h: %s <= %08h#", tc, pc, op, data);
   endfunction

   task automatic drive(input bit kind, input logic [13:0] t, input logic [31:0] pc,
                        input logic [4:0] r, input logic [31:0] addr, input logic [31:0] data);
      rec_kind = kind;
      rec_time = t;
      rec_pc   = pc;
      rec_reg  = r;
      rec_addr = addr;
      rec_data = data;
   endtask

   task automatic scramble();
      rec_kind = 1'($urandom);
      rec_time = 14'($urandom);
      rec_pc   = $urandom;
      rec_reg  = 5'($urandom);
      rec_addr = $urandom;
      rec_data = $urandom;
   endtask

   function automatic logic [13:0] rand_time();
      case ($urandom_range(0, 3))
         0:       return 14'($urandom_range(0, 9));
         1:       return 14'($urandom_range(10, 999));
         2:       return 14'($urandom_range(1000, 9999));
         default: return 14'($urandom_range(10000, 16383));
      endcase
   endfunction

   // Sends one record from idle (called at a negedge) and checks the full line plus aftermath.
   task automatic run_record(input string name, input bit kind, input logic [13:0] t,
                             input logic [31:0] pc, input logic [4:0] r,
                             input logic [31:0] addr, input logic [31:0] data);
      string exp, got;
      bit    hs_ok;
      exp = model(kind, t, pc, r, addr, data);
      checks++;
      if (rec_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s ready_idle: got %b want 1", name, rec_ready);
      end
      drive(kind, t, pc, r, addr, data);
      rec_valid = 1'b1;
      @(negedge clk);
      rec_valid = 1'b0;
      got   = "";
      hs_ok = 1'b1;
      for (int i = 0; i < exp.len(); i++) begin
         if (char_valid !== 1'b1) hs_ok = 1'b0;
         if (rec_ready !== ((i == exp.len() - 1) ? 1'b1 : 1'b0)) hs_ok = 1'b0;
         got = {got, $sformatf("%c", char)};
         scramble();
         @(negedge clk);
      end
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s line: got \"%s\" want \"%s\"", name, got, exp);
      end
      checks++;
      if (!hs_ok) begin
         errors++;
         $display("FAIL %s valid_ready: got irregular char_valid/rec_ready want steady", name);
      end
      exp_sent = exp_sent + 16'd1;
      checks++;
      if (char_valid !== 1'b0 || char !== 8'h00) begin
         errors++;
         $display("FAIL %s idle_after: got %b/%h want 0/00", name, char_valid, char);
      end
      checks++;
      if (records_sent !== exp_sent) begin
         errors++;
         $display("FAIL %s records_sent: got %h want %h", name, records_sent, exp_sent);
      end
   endtask

   task automatic test_reset();
      checks++;
      if (char !== 8'h00 || char_valid !== 1'b0 || records_sent !== 16'h0000) begin
         errors++;
         $display("FAIL reset_state: got %h/%b/%h want 00/0/0000", char, char_valid, records_sent);
      end
      @(negedge clk);
      reset = 1'b1;
      #1;
      checks++;
      if (rec_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_ready: got %b want 1", rec_ready);
      end
      @(negedge clk);
   endtask

   task automatic test_reg_write();
      run_record("reg_write", 1'b0, 14'd42, 32'h00003004, 5'd28, 32'h0, 32'hff00ff00);
   endtask

   task automatic test_mem_write();
      run_record("mem_write", 1'b1, 14'd0, 32'h00003000, 5'd0, 32'h0000abcd, 32'h12345678);
   endtask

   task automatic test_boundaries();
      run_record("clamp_reg0", 1'b0, 14'd16383, 32'h89abcdef, 5'd0, 32'h0, 32'h00000001);
      run_record("time9_reg31", 1'b0, 14'd9, 32'hdeadbeef, 5'd31, 32'h0, 32'hffffffff);
      run_record("time9999", 1'b1, 14'd9999, 32'h0, 5'd0, 32'hffffffff, 32'h0);
   endtask

   task automatic test_random();
      for (int n = 0; n < 10; n++) begin
         run_record($sformatf("random%0d", n), 1'($urandom), rand_time(), $urandom,
                    5'($urandom), $urandom, $urandom);
      end
   endtask

   task automatic test_back_to_back();
      string expa, expb, got;
      bit    v_ok;
      expa = model(1'b0, 14'd20000 - 14'd3617, 32'h00001000, 5'd7, 32'h0, 32'h0badf00d);
      expb = model(1'b1, 14'd123, 32'h00001004, 5'd0, 32'hcafe0000, 32'h00c0ffee);
      drive(1'b0, 14'd20000 - 14'd3617, 32'h00001000, 5'd7, 32'h0, 32'h0badf00d);
      rec_valid = 1'b1;
      @(negedge clk);
      drive(1'b1, 14'd123, 32'h00001004, 5'd0, 32'hcafe0000, 32'h00c0ffee);
      got  = "";
      v_ok = 1'b1;
      for (int i = 0; i < expa.len() + expb.len(); i++) begin
         if (char_valid !== 1'b1) v_ok = 1'b0;
         got = {got, $sformatf("%c", char)};
         if (i >= expa.len()) begin
            rec_valid = 1'b0;
            scramble();
         end
         @(negedge clk);
      end
      checks++;
      if (got != {expa, expb}) begin
         errors++;
         $display("FAIL b2b_lines: got \"%s\" want \"%s%s\"", got, expa, expb);
      end
      checks++;
      if (!v_ok) begin
         errors++;
         $display("FAIL b2b_valid: got gap in char_valid want none");
      end
      exp_sent = exp_sent + 16'd2;
      checks++;
      if (records_sent !== exp_sent) begin
         errors++;
         $display("FAIL b2b_records_sent: got %h want %h", records_sent, exp_sent);
      end
   endtask

   task automatic test_reset_mid();
      string exp;
      int    idx;
      exp = model(1'b0, 14'd512, 32'h76543210, 5'd19, 32'h0, 32'h11112222);
      idx = 0;
      for (int i = 0; i < exp.len(); i++) if (exp[i] == "@" && idx == 0) idx = i + 3;
      drive(1'b0, 14'd512, 32'h76543210, 5'd19, 32'h0, 32'h11112222);
      rec_valid = 1'b1;
      @(negedge clk);
      rec_valid = 1'b0;
      for (int i = 0; i < idx; i++) @(negedge clk);
      checks++;
      if (char !== exp[idx]) begin
         errors++;
         $display("FAIL mid_pc_digit: got %h want %h", char, exp[idx]);
      end
      #2;
      reset = 1'b0;
      #1;
      exp_sent = 16'h0000;
      checks++;
      if (char !== 8'h00 || char_valid !== 1'b0 || records_sent !== exp_sent) begin
         errors++;
         $display("FAIL mid_reset_async: got %h/%b/%h want 00/0/0000",
                  char, char_valid, records_sent);
      end
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (char_valid !== 1'b0 || records_sent !== exp_sent) begin
         errors++;
         $display("FAIL mid_reset_after: got %b/%h want 0/%h", char_valid, records_sent,
                  exp_sent);
      end
      run_record("after_reset", 1'b1, 14'd77, 32'h00400000, 5'd0, 32'h80000000, 32'h0000beef);
   endtask

   task automatic test_wrap();
      force dut.records_sent_q = 16'hffff;
      @(negedge clk);
      release dut.records_sent_q;
      exp_sent = 16'hffff;
      #1;
      checks++;
      if (records_sent !== exp_sent) begin
         errors++;
         $display("FAIL wrap_preset: got %h want %h", records_sent, exp_sent);
      end
      @(negedge clk);
      run_record("wrap", 1'b0, 14'd1, 32'h0, 5'd1, 32'h0, 32'h1);
   endtask

   initial begin
      reset     = 1'b0;
      rec_valid = 1'b0;
      drive(1'b0, 14'd0, 32'h0, 5'd0, 32'h0, 32'h0);
      #3;
      test_reset();
      test_reg_write();
      test_mem_write();
      test_boundaries();
      test_random();
      test_back_to_back();
      test_reset_mid();
      test_wrap();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
